imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Parametrised, pipelined RV32I/RV64I immediate generator for the decode stage.
- Decodes all immediate formats (I, S, B, U, J) from the opcode, sign-extends the result to XLEN and computes pc+imm for branch, jump and AUIPC targets.
- Registers the result behind a valid/ready handshake with a one-entry skid buffer, so fetch and execute can stall independently.
- Flags illegal or unsupported encodings.

Parameters:
- XLEN, 32, datapath width for the immediate, PC and target (32 or 64).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all buffered entries.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  block can accept this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  PC of in_inst.
- out_valid  out  1  out_* fields are valid.
- out_ready  in  1  downstream accepts.
- out_imm  out  XLEN  sign-extended immediate.
- out_fmt  out  3  format code: I=0, S=1, B=2, U=3, J=4, Z=5, NONE=6, BAD=7.
- out_target  out  XLEN  out_pc + out_imm, modulo 2^XLEN.
- out_pc  out  XLEN  forwarded PC.
- out_illegal  out  1  encoding not recognised.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, skid valid=0, in_ready=1, out_imm/out_target/out_pc=0, out_fmt=NONE, out_illegal=0. Reset mid-transfer drops all entries.
- Opcode map (inst[6:0]):
  - I format: 0000011 LOAD, 0010011 OP-IMM, 1100111 JALR, 0001111 MISC-MEM, 1110011 SYSTEM.
  - 0100011 STORE -> S. 1100011 BRANCH -> B. 0110111 LUI and 0010111 AUIPC -> U. 1101111 JAL -> J.
  - 0110011 OP -> NONE, imm=0.
  - Any other opcode, or inst[1:0]!=2'b11 -> BAD, imm=0, illegal=1.
- Immediate construction (sign bit is inst[31], extended to XLEN):
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
- out_target is always computed as pc+imm. The consumer uses it only for B, J and AUIPC; JALR needs rs1 and is out of scope.
- Decode is combinational on the input; results are registered. Latency is 1 cycle from an in_valid&&in_ready edge to out_valid.
- Handshake:
  - A transfer occurs on valid&&ready at a rising clk.
  - out_* stays stable while out_valid && !out_ready.
  - in_ready is a registered signal equal to !skid_valid. It never depends combinationally on out_ready.
- Skid buffer behaviour:
  - Input accepted while output holds an unaccepted entry: the decoded entry goes to the skid and in_ready drops next cycle.
  - Output accepted while skid is full: the skid moves to the output and in_ready rises next cycle.
  - Output accepted and input accepted in the same cycle, skid empty: the new entry goes directly to the output with no bubble.
- Ordering: entries leave strictly in arrival order; no drops, no duplicates.
- flush: clears out_valid and skid valid at the next edge and ignores in_valid in that cycle. in_ready=1 the cycle after. flush has priority over every other event.
- Throughput: 1 instruction per cycle while out_ready is held high.

Optional Feature:
- Macro IMM_ZICSR_EN.
- Defined: SYSTEM with funct3[2]=1 (CSRRWI/CSRRSI/CSRRCI) -> fmt Z, imm = zero-extended inst[19:15].
- Not defined: these decode as I, imm = sign-extended inst[31:20], and fmt Z is never produced.

Decomposition:
- Shared package imm_pkg: opcode localparams, the fmt code enumeration (imm_fmt_t), and XLEN default.
- One natural sub-module, imm_decode (purely combinational): inst -> {imm, fmt, illegal}.
- imm_gen_pipe holds the adder, output register, skid register and handshake logic.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, in_ready=1, out_fmt=NONE. Release -> first output appears 1 cycle after the first accepted input.
- Formats, out_ready=1 throughout:
  - addi 0xFFF00093 -> imm 0xFFFFFFFF, fmt I.
  - sw 0x0020A423 -> imm 0x00000008, fmt S.
  - lui 0x123450B7 -> imm 0x12345000, fmt U.
  - beq 0xFE000EE3 at pc 0x100 -> imm 0xFFFFFFFC, fmt B, target 0x000000FC.
- Backpressure: stream 4 instructions with out_ready=0 for 3 cycles -> in_ready drops after 2 are held (output + skid). After release, all 4 emerge in order with no loss.
- Flush: flush=1 while output and skid are both full -> out_valid=0 next cycle, in_ready=1. Input presented during the flush cycle is never emitted.
- Illegal: 0x00000000 and 0x0000007F -> fmt BAD, illegal=1, imm=0.
- Zicsr: csrrwi 0x3002D073 -> with IMM_ZICSR_EN: fmt Z, imm 0x5. Without it: fmt I, imm 0x300.
- Wrap and width: XLEN=64 run, jal -4 at pc 0x0 -> target 0xFFFFFFFFFFFFFFFC.

Source files
------------

// File: rtl/imm_pkg.sv
// imm_pkg: shared opcodes, format codes and immediate helpers
// for the imm_gen_pipe decode-stage immediate generator.
package imm_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_I    = 3'd0,
    FMT_S    = 3'd1,
    FMT_B    = 3'd2,
    FMT_U    = 3'd3,
    FMT_J    = 3'd4,
    FMT_Z    = 3'd5,
    FMT_NONE = 3'd6,
    FMT_BAD  = 3'd7
  } imm_fmt_t;

  function automatic logic [31:0] imm_i(
    input logic [31:0] inst
  );
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(
    input logic [31:0] inst
  );
    return {{20{inst[31]}},
            inst[31:25], inst[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(
    input logic [31:0] inst
  );
    return {{19{inst[31]}}, inst[31],
            inst[7], inst[30:25],
            inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(
    input logic [31:0] inst
  );
    return {inst[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(
    input logic [31:0] inst
  );
    return {{11{inst[31]}}, inst[31],
            inst[19:12], inst[20],
            inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: upstream/downstream handshake bundle;
// master = pipeline neighbours, slave = imm_gen_pipe.
interface imm_gen_pipe_if
  import imm_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic [XLEN-1:0] out_target;
  logic [XLEN-1:0] out_pc;
  logic            out_illegal;

  modport master (
    output in_valid,
    output in_inst,
    output in_pc,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_imm,
    input  out_fmt,
    input  out_target,
    input  out_pc,
    input  out_illegal
  );

  modport slave (
    input  in_valid,
    input  in_inst,
    input  in_pc,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_imm,
    output out_fmt,
    output out_target,
    output out_pc,
    output out_illegal
  );

endinterface

// File: rtl/imm_decode.sv
// imm_decode: combinational inst -> {imm, fmt, illegal}.
// Optional CSR-immediate decode enabled by IMM_ZICSR_EN.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output imm_fmt_t        fmt,
  output logic            illegal
);

  logic [6:0]  opc;
  logic [31:0] imm32;
  logic        is_sys;
  logic        is_z;
  logic        is_i;
  logic        is_s;
  logic        is_b;
  logic        is_u;
  logic        is_j;
  logic        is_op;

  assign opc    = inst[6:0];
  assign is_sys = (opc == OPC_SYSTEM);

`ifdef IMM_ZICSR_EN
  assign is_z = is_sys && inst[14];
`else
  assign is_z = 1'b0;
`endif

  assign is_i = ((opc == OPC_LOAD)  ||
                 (opc == OPC_OPIMM) ||
                 (opc == OPC_JALR)  ||
                 (opc == OPC_MISC)  ||
                 is_sys) && !is_z;
  assign is_s  = (opc == OPC_STORE);
  assign is_b  = (opc == OPC_BRANCH);
  assign is_u  = (opc == OPC_LUI) ||
                 (opc == OPC_AUIPC);
  assign is_j  = (opc == OPC_JAL);
  assign is_op = (opc == OPC_OP);

  // format select; full 7-bit compares also reject inst[1:0]!=11
  always_comb begin
    imm32   = 32'd0;
    fmt     = FMT_BAD;
    illegal = 1'b0;
    unique case (1'b1)
      is_z: begin
        imm32 = {27'd0, inst[19:15]};
        fmt   = FMT_Z;
      end
      is_i: begin
        imm32 = imm_i(inst);
        fmt   = FMT_I;
      end
      is_s: begin
        imm32 = imm_s(inst);
        fmt   = FMT_S;
      end
      is_b: begin
        imm32 = imm_b(inst);
        fmt   = FMT_B;
      end
      is_u: begin
        imm32 = imm_u(inst);
        fmt   = FMT_U;
      end
      is_j: begin
        imm32 = imm_j(inst);
        fmt   = FMT_J;
      end
      is_op: begin
        fmt = FMT_NONE;
      end
      default: begin
        fmt     = FMT_BAD;
        illegal = 1'b1;
      end
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with a one-entry
// skid buffer; IMM_ZICSR_EN adds CSR-immediate (fmt Z) decode.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  imm_gen_pipe_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc;
    imm_fmt_t        fmt;
    logic            illegal;
  } ent_t;

  localparam ent_t ENT_RST = '{
    imm:     '0,
    target:  '0,
    pc:      '0,
    fmt:     FMT_NONE,
    illegal: 1'b0
  };

  logic [XLEN-1:0] dec_imm;
  imm_fmt_t        dec_fmt;
  logic            dec_ill;
  ent_t            dec_e;

  ent_t out_q;
  ent_t out_d;
  ent_t skid_q;
  ent_t skid_d;
  logic out_v;
  logic out_v_d;
  logic skid_v;
  logic skid_v_d;
  logic rdy_q;

  logic acc_in;
  logic out_fire;

  imm_decode #(
    .XLEN (XLEN)
  ) u_dec (
    .inst    (bus.in_inst),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_ill)
  );

  // pack the decoded entry; target wraps mod 2^XLEN
  always_comb begin
    dec_e         = ENT_RST;
    dec_e.imm     = dec_imm;
    dec_e.target  = bus.in_pc + dec_imm;
    dec_e.pc      = bus.in_pc;
    dec_e.fmt     = dec_fmt;
    dec_e.illegal = dec_ill;
  end

  assign acc_in   = bus.in_valid && rdy_q;
  assign out_fire = out_v && bus.out_ready;

  // next state of output slot and skid; flush wins
  always_comb begin
    out_v_d  = out_v;
    skid_v_d = skid_v;
    out_d    = out_q;
    skid_d   = skid_q;
    if (flush) begin
      out_v_d  = 1'b0;
      skid_v_d = 1'b0;
    end else if (skid_v) begin
      if (out_fire) begin
        out_d    = skid_q;
        skid_v_d = 1'b0;
      end
    end else if (acc_in) begin
      if (!out_v || bus.out_ready) begin
        out_d   = dec_e;
        out_v_d = 1'b1;
      end else begin
        skid_d   = dec_e;
        skid_v_d = 1'b1;
      end
    end else if (out_fire) begin
      out_v_d = 1'b0;
    end
  end

  // valid flags and registered ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      rdy_q  <= 1'b1;
    end else begin
      out_v  <= out_v_d;
      skid_v <= skid_v_d;
      rdy_q  <= !skid_v_d;
    end
  end

  // entry payload registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= ENT_RST;
      skid_q <= ENT_RST;
    end else begin
      out_q  <= out_d;
      skid_q <= skid_d;
    end
  end

  assign bus.in_ready    = rdy_q;
  assign bus.out_valid   = out_v;
  assign bus.out_imm     = out_q.imm;
  assign bus.out_fmt     = out_q.fmt;
  assign bus.out_target  = out_q.target;
  assign bus.out_pc      = out_q.pc;
  assign bus.out_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed checks of imm_gen_pipe at XLEN=32
// and XLEN=64; IMM_ZICSR_EN selects the CSR-immediate expectation.
module tb_imm_gen_pipe;

  logic clk;
  logic rst_n;
  logic flush;

  int n_run;
  int n_fail;

  imm_gen_pipe_if #(.XLEN(32)) if32 ();
  imm_gen_pipe_if #(.XLEN(64)) if64 ();

  imm_gen_pipe #(.XLEN(32)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (if32)
  );

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (if64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(
    input logic [31:0] inst,
    input logic [31:0] pc
  );
    if32.in_valid = 1'b1;
    if32.in_inst  = inst;
    if32.in_pc    = pc;
  endtask

  task automatic send(
    input logic [31:0] inst,
    input logic [31:0] pc
  );
    put(inst, pc);
    tick();
    if32.in_valid = 1'b0;
  endtask

  task automatic chk_out(
    input string       tag,
    input logic [31:0] imm,
    input logic [2:0]  fmt,
    input logic        ill
  );
    chk({tag, ".v"}, 64'(if32.out_valid), 64'd1);
    chk({tag, ".imm"}, 64'(if32.out_imm), 64'(imm));
    chk({tag, ".fmt"}, 64'(if32.out_fmt), 64'(fmt));
    chk({tag, ".ill"}, 64'(if32.out_illegal), 64'(ill));
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    flush  = 1'b0;
    rst_n  = 1'b0;
    put(32'hFFF00093, 32'h0);
    if32.out_ready = 1'b1;
    if64.in_valid  = 1'b0;
    if64.in_inst   = 32'h0;
    if64.in_pc     = 64'h0;
    if64.out_ready = 1'b1;

    // reset held with in_valid high
    tick();
    tick();
    chk("rst.v", 64'(if32.out_valid), 64'd0);
    chk("rst.rdy", 64'(if32.in_ready), 64'd1);
    chk("rst.fmt", 64'(if32.out_fmt), 64'd6);
    chk("rst.imm", 64'(if32.out_imm), 64'd0);
    chk("rst.tgt", 64'(if32.out_target), 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    chk("lat.pre", 64'(if32.out_valid), 64'd0);
    tick();
    if32.in_valid = 1'b0;
    chk_out("addi", 32'hFFFFFFFF, 3'd0, 1'b0);

    send(32'h0020A423, 32'h0);
    chk_out("sw", 32'h00000008, 3'd1, 1'b0);
    send(32'h123450B7, 32'h0);
    chk_out("lui", 32'h12345000, 3'd3, 1'b0);
    send(32'hFE000EE3, 32'h100);
    chk_out("beq", 32'hFFFFFFFC, 3'd2, 1'b0);
    chk("beq.tgt", 64'(if32.out_target), 64'hFC);
    chk("beq.pc", 64'(if32.out_pc), 64'h100);
    send(32'h00000033, 32'h0);
    chk_out("add", 32'h0, 3'd6, 1'b0);
    send(32'h00000000, 32'h0);
    chk_out("ill0", 32'h0, 3'd7, 1'b1);
    send(32'h0000007F, 32'h0);
    chk_out("ill7f", 32'h0, 3'd7, 1'b1);
    send(32'h3002D073, 32'h0);
`ifdef IMM_ZICSR_EN
    chk_out("csrrwi", 32'h5, 3'd5, 1'b0);
`else
    chk_out("csrrwi", 32'h300, 3'd0, 1'b0);
`endif
    tick();
    chk("idle.v", 64'(if32.out_valid), 64'd0);

    // backpressure: A, B held, C stalls
    if32.out_ready = 1'b0;
    send(32'h00100093, 32'h10);
    chk("bp1.v", 64'(if32.out_valid), 64'd1);
    chk("bp1.rdy", 64'(if32.in_ready), 64'd1);
    send(32'h00200093, 32'h14);
    chk("bp2.rdy", 64'(if32.in_ready), 64'd0);
    chk("bp2.imm", 64'(if32.out_imm), 64'd1);
    put(32'h00300093, 32'h18);
    tick();
    chk("bp3.rdy", 64'(if32.in_ready), 64'd0);
    chk("bp3.imm", 64'(if32.out_imm), 64'd1);
    chk("bp3.pc", 64'(if32.out_pc), 64'h10);
    if32.out_ready = 1'b1;
    tick();
    chk("bpB.imm", 64'(if32.out_imm), 64'd2);
    chk("bpB.pc", 64'(if32.out_pc), 64'h14);
    chk("bpB.rdy", 64'(if32.in_ready), 64'd1);
    tick();
    chk("bpC.imm", 64'(if32.out_imm), 64'd3);
    chk("bpC.pc", 64'(if32.out_pc), 64'h18);
    send(32'h00400093, 32'h1C);
    chk("bpD.imm", 64'(if32.out_imm), 64'd4);
    chk("bpD.v", 64'(if32.out_valid), 64'd1);
    tick();
    chk("bpE.v", 64'(if32.out_valid), 64'd0);

    // flush with output and skid both full
    if32.out_ready = 1'b0;
    send(32'h00100093, 32'h20);
    send(32'h00200093, 32'h24);
    chk("fl.full", 64'(if32.in_ready), 64'd0);
    flush = 1'b1;
    put(32'h00500093, 32'h28);
    tick();
    flush = 1'b0;
    if32.in_valid = 1'b0;
    if32.out_ready = 1'b1;
    chk("fl.v", 64'(if32.out_valid), 64'd0);
    chk("fl.rdy", 64'(if32.in_ready), 64'd1);
    tick();
    chk("fl.v2", 64'(if32.out_valid), 64'd0);

    // flush while empty ignores the input
    flush = 1'b1;
    put(32'h00500093, 32'h2C);
    tick();
    flush = 1'b0;
    if32.in_valid = 1'b0;
    chk("fl2.v", 64'(if32.out_valid), 64'd0);
    tick();
    chk("fl2.v2", 64'(if32.out_valid), 64'd0);

    // XLEN=64: jal -4 at pc 0 wraps
    if64.in_valid = 1'b1;
    if64.in_inst  = 32'hFFDFF06F;
    if64.in_pc    = 64'h0;
    tick();
    if64.in_valid = 1'b0;
    chk("j64.v", 64'(if64.out_valid), 64'd1);
    chk("j64.fmt", 64'(if64.out_fmt), 64'd4);
    chk("j64.imm", if64.out_imm,
        64'hFFFFFFFFFFFFFFFC);
    chk("j64.tgt", if64.out_target,
        64'hFFFFFFFFFFFFFFFC);
    if64.in_valid = 1'b1;
    if64.in_inst  = 32'h123450B7;
    if64.in_pc    = 64'h1000;
    tick();
    if64.in_valid = 1'b0;
    chk("u64.tgt", if64.out_target,
        64'h0000000012346000);

    // reset mid-transfer drops entries
    if32.out_ready = 1'b0;
    send(32'h00100093, 32'h30);
    send(32'h00200093, 32'h34);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst2.v", 64'(if32.out_valid), 64'd0);
    chk("rst2.rdy", 64'(if32.in_ready), 64'd1);
    rst_n = 1'b1;
    if32.out_ready = 1'b1;
    tick();
    chk("rst2.v2", 64'(if32.out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
